// File: rtl/cfg_chain_loader.sv
// Bitstream loader: serialises WORD_W-bit words into NUM_CHAINS tile shift chains, then pulses set.
// Optional readback of the chain tails is compiled in with `define CFG_READBACK_EN.
module cfg_chain_loader #(
  parameter int NUM_CHAINS = 4,
  parameter int WORD_W     = 32,
  parameter int CHAIN_LEN  = 512,
  parameter int SET_PULSE  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [WORD_W-1:0]     i_cfg_data,
  input  logic                  i_cfg_valid,
  output logic                  o_cfg_ready,
  output logic [NUM_CHAINS-1:0] o_chain_data,
  output logic                  o_chain_cen,
  output logic                  o_set_out,
  output logic                  o_busy,
  output logic                  o_done
`ifdef CFG_READBACK_EN
  ,
  input  logic [NUM_CHAINS-1:0] i_chain_tail,
  output logic [WORD_W-1:0]     o_rb_data,
  output logic                  o_rb_valid
`endif
);

  localparam int BEATS = WORD_W / NUM_CHAINS;
  localparam int SC_W  = $clog2(CHAIN_LEN + 1);
  localparam int BT_W  = $clog2(BEATS) + 1;
  localparam int PC_W  = $clog2(SET_PULSE + 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_SET, S_DONE} state_t;

  state_t                             r_state;
  state_t                             w_next;
  // Word buffer viewed as beats of chain bits: beat k, chain c = bit k*NUM_CHAINS+c.
  logic [BEATS-1:0][NUM_CHAINS-1:0]   r_buf;
  logic [SC_W-1:0]                    r_shift_cnt;
  logic [BT_W-1:0]                    r_beat;
  logic [PC_W-1:0]                    r_set_cnt;

  logic                  w_ready;
  logic                  w_cen;
  logic                  w_set;
  logic                  w_done;
  logic                  w_busy;
  logic [NUM_CHAINS-1:0] w_data;
  logic                  w_last_beat;
  logic                  w_last_shift;

  assign w_last_beat  = (r_beat == BT_W'(BEATS - 1));
  assign w_last_shift = (r_shift_cnt == SC_W'(CHAIN_LEN - 1));

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_cen   = 1'b0;
    w_set   = 1'b0;
    w_done  = 1'b0;
    w_busy  = (r_state != S_IDLE);
    w_data  = '0;
    case (r_state)
      S_IDLE:  if (i_start && !i_abort) w_next = S_FETCH;
      S_FETCH: begin
        w_ready = 1'b1;
        if (i_cfg_valid) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        w_cen = 1'b1;
        for (int k = 0; k < BEATS; k++)
          if (r_beat == BT_W'(k)) w_data = r_buf[k];
        if (w_last_beat) w_next = w_last_shift ? S_SET : S_FETCH;
      end
      S_SET: begin
        w_set = 1'b1;
        w_cen = 1'b1;
        if (r_set_cnt == PC_W'(SET_PULSE - 1)) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Abort never issues set, so the tiles keep their live configuration.
    if (r_state != S_IDLE && i_abort) w_next = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_buf       <= '0;
      r_shift_cnt <= '0;
      r_beat      <= '0;
      r_set_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_next == S_FETCH) begin
        r_shift_cnt <= '0;
        r_beat      <= '0;
      end
      if (r_state == S_FETCH && i_cfg_valid) begin
        r_buf  <= i_cfg_data;
        r_beat <= '0;
      end
      if (r_state == S_SHIFT) begin
        r_beat      <= r_beat + 1'b1;
        r_shift_cnt <= r_shift_cnt + 1'b1;
      end
      r_set_cnt <= (r_state == S_SET) ? r_set_cnt + 1'b1 : '0;
    end
  end

  assign o_cfg_ready  = w_ready;
  assign o_chain_cen  = w_cen;
  assign o_set_out    = w_set;
  assign o_done       = w_done;
  assign o_busy       = w_busy;
  assign o_chain_data = w_data;

`ifdef CFG_READBACK_EN
  logic [BEATS-1:0][NUM_CHAINS-1:0] r_rb_data;
  logic                             r_rb_valid;

  // Old config leaves the tails in the same beat order the new one enters the heads.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= (r_state == S_SHIFT) && w_last_beat && !i_abort;
      if (r_state == S_SHIFT)
        for (int k = 0; k < BEATS; k++)
          if (r_beat == BT_W'(k)) r_rb_data[k] <= i_chain_tail;
    end
  end

  assign o_rb_data  = r_rb_data;
  assign o_rb_valid = r_rb_valid;
`endif

endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
- Configuration bitstream loader for the fabric.
- Accepts parallel bitstream words over a valid/ready handshake and serialises them into NUM_CHAINS independent tile shift chains, one bit per chain per cycle. Each chain is one tile column's shift_in/shift_out path.
- After CHAIN_LEN shifts it pulses the chain set line, so every tile latches its new configuration.
- Generalises the single-chain shift/set wiring of a tile to a multi-column, width-parametrised loader with an FSM, abort and optional readback.

Parameters:
- NUM_CHAINS, 4: number of parallel tile shift chains.
- WORD_W, 32: input word width. Must be a multiple of NUM_CHAINS.
- CHAIN_LEN, 512: shifts per chain per load. Must be a multiple of BEATS, where BEATS = WORD_W/NUM_CHAINS.
- SET_PULSE, 2: number of cycles set_out is held high.

Ports:
- clk  in  1  fabric clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  begin a load; sampled only in IDLE.
- abort  in  1  terminate the current load.
- cfg_data  in  WORD_W  bitstream word.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  loader accepts a word this cycle.
- chain_data  out  NUM_CHAINS  bit driven to each chain head (tile shift_in).
- chain_cen  out  1  chain shift enable (tile cen).
- set_out  out  1  configuration set strobe to all chains.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on load completion.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; all counters 0; word buffer 0.
  - cfg_ready, chain_data, chain_cen, set_out, busy and done all 0.
- Bit mapping: on beat k (0..BEATS-1), chain c receives buf[k*NUM_CHAINS+c]. Beat 0 is the LSB group, sent first.
- IDLE:
  - Outputs 0.
  - If start=1 and abort=0, go to FETCH and clear shift_cnt.
- FETCH:
  - cfg_ready=1; chain_cen=0.
  - On cfg_valid&cfg_ready, latch cfg_data into buf, set beat=0, go to SHIFT.
  - Otherwise stay in FETCH, with no timeout.
- SHIFT:
  - chain_cen=1; chain_data = buf group selected by beat; cfg_ready=0.
  - Each cycle, beat and shift_cnt increment.
  - At beat==BEATS-1:
    - if shift_cnt==CHAIN_LEN-1, go to SET;
    - otherwise go to FETCH.
  - Each word therefore costs BEATS+1 cycles when cfg_valid is already high (one fetch bubble).
- SET:
  - set_out=1 and chain_cen=1 for exactly SET_PULSE cycles; chain_data=0.
  - Then go to DONE.
- DONE:
  - done=1 for one cycle; busy=1.
  - Next state is IDLE.
- Counters: shift_cnt width is $clog2(CHAIN_LEN+1) and beat width is $clog2(BEATS)+1. Neither wraps within a load; both are cleared on entry to FETCH from IDLE.
- abort=1 in any non-IDLE state:
  - next state is IDLE;
  - set_out, chain_cen and cfg_ready drop the following cycle;
  - no set pulse and no done;
  - the chains hold partial data, and the tile's live config is untouched because set was never issued.
- abort and start both high in IDLE: abort wins and the loader stays in IDLE.
- start while busy: ignored.
- cfg_valid while not in FETCH: the word is not consumed (cfg_ready=0).
- Reset asserted mid-load: behaves as the reset values above, on the next edge.

Optional Feature:
- Macro CFG_READBACK_EN.
- When defined, adds:
  - chain_tail in NUM_CHAINS: tail shift_out of each chain;
  - rb_data out WORD_W;
  - rb_valid out 1.
- During SHIFT, chain_tail is sampled on each beat into rb_data, using the same bit mapping as the load path.
- rb_valid pulses for one cycle on the cycle after the last beat of each word.
- The old configuration therefore streams out while the new one streams in.
- rb_data and rb_valid reset to 0. Abort suppresses any pending rb_valid.
- When the macro is undefined, these ports and their logic are absent.

Test Plan (NUM_CHAINS=4, WORD_W=8, CHAIN_LEN=4, BEATS=2, SET_PULSE=2 unless noted):
- Basic load:
  - Stimulus: start, then words 0x3C, 0xA5 with cfg_valid held high.
  - Required: chain_data sequence 4'hC, 4'h3, 4'h5, 4'hA, with chain_cen high on exactly those 4 cycles. Then set_out high for 2 cycles, done 1 cycle, busy low the cycle after done.
- Backpressure:
  - Stimulus: cfg_valid low for 5 cycles in FETCH between words.
  - Required: cfg_ready stays 1, chain_cen stays 0, shift_cnt holds; the output sequence is identical to the basic load.
- Abort:
  - Stimulus: abort during the second beat of word 0.
  - Required: next cycle busy=0 and chain_cen=0; set_out and done never assert; a following start performs a full clean load.
- Reset mid-SET:
  - Stimulus: rst=0 on the first SET cycle.
  - Required: set_out=0 at the next edge, state IDLE, all outputs 0.
- Start while busy / start with abort:
  - Stimulus: start pulses mid-SHIFT; separately, start and abort together in IDLE.
  - Required: neither changes state or counts.
- CFG_READBACK_EN:
  - Stimulus: chain_tail driven 4'h1 then 4'hF on the beats of word 0.
  - Required: rb_data=8'hF1 with rb_valid for 1 cycle after beat 1.
